// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage types and address-field helpers for the next-PC generator
// and its branch target buffer.
package fetch_pkg;

  localparam int ADDR_WIDTH    = 64;
  localparam int BTB_SET_COUNT = 32;
  localparam int INDEX_WIDTH   = 5;
  localparam int TAG_WIDTH     = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 64'h0000_0000_0000_0000;

  // Targets drop the two always-zero low bits of a word-aligned address.
  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-3:0] target;
  } btb_entry_t;

  function automatic logic [INDEX_WIDTH-1:0] pc_index(input logic [ADDR_WIDTH-1:0] pc);
    return pc[INDEX_WIDTH+1:2];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] pc_tag(input logic [ADDR_WIDTH-1:0] pc);
    return pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-stage bundle: exec redirect/BTB-update traffic, BHT hookup and
// the prediction outputs. The master side is the environment, the slave side the PC generator.
interface fetch_pc_gen_if;
  import fetch_pkg::*;

  logic                   i_stall_fetch;
  logic                   i_redirect;
  logic [ADDR_WIDTH-1:0]  i_redirect_pc;
  logic                   i_btb_update;
  logic [ADDR_WIDTH-1:0]  i_btb_update_pc;
  logic [ADDR_WIDTH-1:0]  i_btb_update_target;
  logic                   i_bht_pred_taken;
  logic [ADDR_WIDTH-1:0]  o_pc_fetch;
  logic [ADDR_WIDTH-1:0]  o_pc_plus4;
  logic [INDEX_WIDTH-1:0] o_bht_set_index;
  logic                   o_pred_taken;
  logic [ADDR_WIDTH-1:0]  o_pred_target;

  modport master (
    output i_stall_fetch, i_redirect, i_redirect_pc, i_btb_update,
           i_btb_update_pc, i_btb_update_target, i_bht_pred_taken,
    input  o_pc_fetch, o_pc_plus4, o_bht_set_index, o_pred_taken, o_pred_target
  );

  modport slave (
    input  i_stall_fetch, i_redirect, i_redirect_pc, i_btb_update,
           i_btb_update_pc, i_btb_update_target, i_bht_pred_taken,
    output o_pc_fetch, o_pc_plus4, o_bht_set_index, o_pred_taken, o_pred_target
  );

endinterface

// File: rtl/fetch_pc_gen_btb_mem.sv
// Direct-mapped branch target buffer: combinational lookup, gated synchronous write.
// Only the valid bits are reset; tag and target storage is left uninitialised.
module btb_mem
  import fetch_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_pc,
  input  logic [ADDR_WIDTH-1:0] wr_target,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] hit_target
);

  logic [BTB_SET_COUNT-1:0] valid_q;
  logic [TAG_WIDTH-1:0]     tag_q    [BTB_SET_COUNT];
  logic [ADDR_WIDTH-3:0]    target_q [BTB_SET_COUNT];
  btb_entry_t               rd_entry;
  btb_entry_t               wr_entry;
  logic                     unused_low_bits;

  // Low address bits are implied zero for 4-byte instructions.
  assign unused_low_bits = ^{lookup_pc[1:0], wr_pc[1:0], wr_target[1:0]};

  always_comb begin
    wr_entry        = '0;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = pc_tag(wr_pc);
    wr_entry.target = wr_target[ADDR_WIDTH-1:2];
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[pc_index(wr_pc)] <= wr_entry.valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && i_arst_n) begin
      tag_q[pc_index(wr_pc)]    <= wr_entry.tag;
      target_q[pc_index(wr_pc)] <= wr_entry.target;
    end
  end

  // Reads see pre-write contents; a same-cycle write shows up next cycle.
  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[pc_index(lookup_pc)];
    rd_entry.tag    = tag_q[pc_index(lookup_pc)];
    rd_entry.target = target_q[pc_index(lookup_pc)];
    hit             = rd_entry.valid && (rd_entry.tag == pc_tag(lookup_pc));
    hit_target      = {rd_entry.target, 2'b00};
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register and next-PC selection: redirect, stall, predicted-taken
// BTB target, or sequential PC+4.
module fetch_pc_gen
  import fetch_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_arst_n,
  fetch_pc_gen_if.slave bus
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic                  btb_hit;
  logic                  btb_wr_en;
  logic                  pred_taken;

  // BTB writes share the stall gate with the BHT update path.
  assign btb_wr_en = bus.i_btb_update && !bus.i_stall_fetch;

  btb_mem u_btb_mem (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .lookup_pc  (pc_q),
    .wr_en      (btb_wr_en),
    .wr_pc      (bus.i_btb_update_pc),
    .wr_target  (bus.i_btb_update_target),
    .hit        (btb_hit),
    .hit_target (btb_target)
  );

  always_comb begin
    pc_plus4   = pc_q + ADDR_WIDTH'(4);
    pred_taken = btb_hit && bus.i_bht_pred_taken;
    pc_next    = pc_plus4;
    if (bus.i_redirect) begin
      pc_next = bus.i_redirect_pc & ~ADDR_WIDTH'(3);
    end else if (bus.i_stall_fetch) begin
      pc_next = pc_q;
    end else if (pred_taken) begin
      pc_next = btb_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign bus.o_pc_fetch      = pc_q;
  assign bus.o_pc_plus4      = pc_plus4;
  assign bus.o_bht_set_index = pc_index(pc_q);
  assign bus.o_pred_taken    = pred_taken;
  assign bus.o_pred_target   = btb_hit ? btb_target : pc_plus4;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen: reset, BTB hit/miss/alias,
// redirect under stall, gated writes, same-cycle write/lookup, wrap, reset mid-run.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  logic i_clk;
  logic i_arst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_pc_gen_if bus ();

  fetch_pc_gen dut (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .bus      (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_idle();
    bus.i_stall_fetch       = 1'b0;
    bus.i_redirect          = 1'b0;
    bus.i_redirect_pc       = '0;
    bus.i_btb_update        = 1'b0;
    bus.i_btb_update_pc     = '0;
    bus.i_btb_update_target = '0;
    bus.i_bht_pred_taken    = 1'b0;
  endtask

  task automatic do_redirect(input logic [ADDR_WIDTH-1:0] addr);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = addr;
    step();
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
  endtask

  task automatic test_reset();
    logic [ADDR_WIDTH-1:0] exp_pc;
    i_arst_n = 1'b0;
    set_idle();
    #2;
    checks++;
    if (bus.o_pc_fetch !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_pc got %h want %h", bus.o_pc_fetch, 64'h0);
    end
    checks++;
    if (bus.o_pc_plus4 !== 64'h4) begin
      errors++; $display("[TB] FAIL reset_plus4 got %h want %h", bus.o_pc_plus4, 64'h4);
    end
    checks++;
    if (bus.o_pred_target !== 64'h4 || bus.o_pred_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pred got taken=%b tgt=%h want 0/%h",
                         bus.o_pred_taken, bus.o_pred_target, 64'h4);
    end
    step();
    step();
    @(negedge i_clk);
    i_arst_n = 1'b1;
    exp_pc = 64'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_pc_fetch !== exp_pc || bus.o_pred_taken !== 1'b0) begin
        errors++; $display("[TB] FAIL seq_pc[%0d] got %h/%b want %h/0",
                           i, bus.o_pc_fetch, bus.o_pred_taken, exp_pc);
      end
      step();
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  task automatic test_btb_hit();
    bus.i_btb_update        = 1'b1;
    bus.i_btb_update_pc     = 64'h40;
    bus.i_btb_update_target = 64'h200;
    step();
    bus.i_btb_update = 1'b0;
    do_redirect(64'h40);
    bus.i_bht_pred_taken = 1'b1;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b1 || bus.o_pred_target !== 64'h200) begin
      errors++; $display("[TB] FAIL hit_pred got %b/%h want 1/%h",
                         bus.o_pred_taken, bus.o_pred_target, 64'h200);
    end
    checks++;
    if (bus.o_bht_set_index !== 5'h10) begin
      errors++; $display("[TB] FAIL hit_index got %h want %h", bus.o_bht_set_index, 5'h10);
    end
    step();
    bus.i_bht_pred_taken = 1'b0;
    checks++;
    if (bus.o_pc_fetch !== 64'h200) begin
      errors++; $display("[TB] FAIL hit_next_pc got %h want %h", bus.o_pc_fetch, 64'h200);
    end
  endtask

  task automatic test_not_taken_and_alias();
    do_redirect(64'h40);
    bus.i_bht_pred_taken = 1'b0;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b0 || bus.o_pred_target !== 64'h200) begin
      errors++; $display("[TB] FAIL nt_pred got %b/%h want 0/%h",
                         bus.o_pred_taken, bus.o_pred_target, 64'h200);
    end
    step();
    checks++;
    if (bus.o_pc_fetch !== 64'h44) begin
      errors++; $display("[TB] FAIL nt_next_pc got %h want %h", bus.o_pc_fetch, 64'h44);
    end
    do_redirect(64'hC0);
    bus.i_bht_pred_taken = 1'b1;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b0 || bus.o_pred_target !== 64'hC4 ||
        bus.o_bht_set_index !== 5'h10) begin
      errors++; $display("[TB] FAIL alias_pred got %b/%h/%h want 0/%h/%h",
                         bus.o_pred_taken, bus.o_pred_target, bus.o_bht_set_index,
                         64'hC4, 5'h10);
    end
    step();
    bus.i_bht_pred_taken = 1'b0;
    checks++;
    if (bus.o_pc_fetch !== 64'hC4) begin
      errors++; $display("[TB] FAIL alias_next_pc got %h want %h", bus.o_pc_fetch, 64'hC4);
    end
  endtask

  task automatic test_stall_redirect();
    bus.i_stall_fetch = 1'b1;
    do_redirect(64'h1003);
    checks++;
    if (bus.o_pc_fetch !== 64'h1000) begin
      errors++; $display("[TB] FAIL stall_redirect got %h want %h", bus.o_pc_fetch, 64'h1000);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.o_pc_fetch !== 64'h1000) begin
        errors++; $display("[TB] FAIL stall_hold[%0d] got %h want %h",
                           i, bus.o_pc_fetch, 64'h1000);
      end
    end
    bus.i_stall_fetch = 1'b0;
    step();
    checks++;
    if (bus.o_pc_fetch !== 64'h1004) begin
      errors++; $display("[TB] FAIL stall_release got %h want %h", bus.o_pc_fetch, 64'h1004);
    end
  endtask

  task automatic test_gated_update();
    bus.i_stall_fetch       = 1'b1;
    bus.i_btb_update        = 1'b1;
    bus.i_btb_update_pc     = 64'h300;
    bus.i_btb_update_target = 64'h500;
    step();
    bus.i_stall_fetch = 1'b0;
    bus.i_btb_update  = 1'b0;
    do_redirect(64'h300);
    bus.i_bht_pred_taken = 1'b1;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b0 || bus.o_pred_target !== 64'h304) begin
      errors++; $display("[TB] FAIL gated_write got %b/%h want 0/%h",
                         bus.o_pred_taken, bus.o_pred_target, 64'h304);
    end
    step();
    bus.i_bht_pred_taken = 1'b0;
    checks++;
    if (bus.o_pc_fetch !== 64'h304) begin
      errors++; $display("[TB] FAIL gated_next_pc got %h want %h", bus.o_pc_fetch, 64'h304);
    end
  endtask

  task automatic test_same_cycle();
    do_redirect(64'h14);
    bus.i_btb_update        = 1'b1;
    bus.i_btb_update_pc     = 64'h14;
    bus.i_btb_update_target = 64'h800;
    bus.i_bht_pred_taken    = 1'b1;
    #1;
    checks++;
    if (bus.o_bht_set_index !== 5'h05 || bus.o_pred_taken !== 1'b0 ||
        bus.o_pred_target !== 64'h18) begin
      errors++; $display("[TB] FAIL same_cycle_miss got %h/%b/%h want %h/0/%h",
                         bus.o_bht_set_index, bus.o_pred_taken, bus.o_pred_target,
                         5'h05, 64'h18);
    end
    step();
    bus.i_btb_update     = 1'b0;
    bus.i_bht_pred_taken = 1'b0;
    checks++;
    if (bus.o_pc_fetch !== 64'h18) begin
      errors++; $display("[TB] FAIL same_cycle_next got %h want %h", bus.o_pc_fetch, 64'h18);
    end
    do_redirect(64'h14);
    bus.i_bht_pred_taken = 1'b1;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b1 || bus.o_pred_target !== 64'h800) begin
      errors++; $display("[TB] FAIL same_cycle_later_hit got %b/%h want 1/%h",
                         bus.o_pred_taken, bus.o_pred_target, 64'h800);
    end
    step();
    bus.i_bht_pred_taken = 1'b0;
    checks++;
    if (bus.o_pc_fetch !== 64'h800) begin
      errors++; $display("[TB] FAIL same_cycle_jump got %h want %h", bus.o_pc_fetch, 64'h800);
    end
  endtask

  task automatic test_redirect_with_update();
    bus.i_btb_update        = 1'b1;
    bus.i_btb_update_pc     = 64'h60;
    bus.i_btb_update_target = 64'h903;
    do_redirect(64'h2000);
    bus.i_btb_update = 1'b0;
    checks++;
    if (bus.o_pc_fetch !== 64'h2000) begin
      errors++; $display("[TB] FAIL dual_redirect got %h want %h", bus.o_pc_fetch, 64'h2000);
    end
    do_redirect(64'h60);
    bus.i_bht_pred_taken = 1'b1;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b1 || bus.o_pred_target !== 64'h900) begin
      errors++; $display("[TB] FAIL dual_update got %b/%h want 1/%h",
                         bus.o_pred_taken, bus.o_pred_target, 64'h900);
    end
    bus.i_bht_pred_taken = 1'b0;
  endtask

  task automatic test_wrap();
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    checks++;
    if (bus.o_pc_plus4 !== 64'h0 || bus.o_bht_set_index !== 5'h1F) begin
      errors++; $display("[TB] FAIL wrap_plus4 got %h/%h want %h/%h",
                         bus.o_pc_plus4, bus.o_bht_set_index, 64'h0, 5'h1F);
    end
    step();
    checks++;
    if (bus.o_pc_fetch !== 64'h0) begin
      errors++; $display("[TB] FAIL wrap_pc got %h want %h", bus.o_pc_fetch, 64'h0);
    end
  endtask

  task automatic test_reset_midrun();
    do_redirect(64'h500);
    @(negedge i_clk);
    bus.i_redirect          = 1'b1;
    bus.i_redirect_pc       = 64'h3000;
    bus.i_btb_update        = 1'b1;
    bus.i_btb_update_pc     = 64'h80;
    bus.i_btb_update_target = 64'h700;
    #1;
    i_arst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_pc_fetch !== RESET_PC) begin
      errors++; $display("[TB] FAIL midrun_async_pc got %h want %h", bus.o_pc_fetch, RESET_PC);
    end
    step();
    set_idle();
    @(negedge i_clk);
    i_arst_n = 1'b1;
    checks++;
    if (bus.o_pc_fetch !== RESET_PC) begin
      errors++; $display("[TB] FAIL midrun_discard got %h want %h", bus.o_pc_fetch, RESET_PC);
    end
    do_redirect(64'h40);
    bus.i_bht_pred_taken = 1'b1;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b0 || bus.o_pred_target !== 64'h44) begin
      errors++; $display("[TB] FAIL midrun_btb_cleared got %b/%h want 0/%h",
                         bus.o_pred_taken, bus.o_pred_target, 64'h44);
    end
    bus.i_bht_pred_taken = 1'b0;
    do_redirect(64'h80);
    bus.i_bht_pred_taken = 1'b1;
    #1;
    checks++;
    if (bus.o_pred_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_update_dropped got %b want 0", bus.o_pred_taken);
    end
    bus.i_bht_pred_taken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_btb_hit();
    test_not_taken_and_alias();
    test_stall_redirect();
    test_gated_update();
    test_same_cycle();
    test_redirect_with_update();
    test_wrap();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Fetch-stage next-PC generator, directly upstream of the 2-bit-counter BHT.
- Holds the fetch PC register and drives the BHT read index.
- Owns a direct-mapped BTB (valid/tag/target).
- Combines a BTB hit with the BHT taken bit to pick the next fetch PC.
- Accepts redirect and BTB-update traffic from the execute stage.

Parameters:
ADDR_WIDTH, 64, PC/target width in bits.
BTB_SET_COUNT, 32, BTB entries; equals the BHT set count.
INDEX_WIDTH, 5, log2(BTB_SET_COUNT); also the BHT index width.
RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset; word-aligned.

Ports:
i_clk  in  1  clock.
i_arst_n  in  1  asynchronous active-low reset.
i_stall_fetch  in  1  hold PC; gate BTB writes.
i_redirect  in  1  exec mispredict/jump; forces next PC.
i_redirect_pc  in  ADDR_WIDTH  correct next PC from exec.
i_btb_update  in  1  write a BTB entry (taken branch or jump resolved in exec).
i_btb_update_pc  in  ADDR_WIDTH  PC of the resolved branch.
i_btb_update_target  in  ADDR_WIDTH  resolved target.
i_bht_pred_taken  in  1  BHT taken bit for o_bht_set_index, same cycle.
o_pc_fetch  out  ADDR_WIDTH  current fetch PC.
o_pc_plus4  out  ADDR_WIDTH  o_pc_fetch + 4.
o_bht_set_index  out  INDEX_WIDTH  o_pc_fetch[INDEX_WIDTH+1:2], to the BHT read index.
o_pred_taken  out  1  btb_hit & i_bht_pred_taken; piped with the instruction for exec mispredict check.
o_pred_target  out  ADDR_WIDTH  BTB target on hit, else o_pc_plus4.

Behaviour:
- Reset, async on i_arst_n low:
  - PC = RESET_PC.
  - All BTB valid bits = 0. Tags/targets are not reset.
  - Outputs after reset: o_pc_fetch=RESET_PC, o_pc_plus4=RESET_PC+4, o_pred_taken=0, o_pred_target=RESET_PC+4.
  - Reset asserted mid-operation discards any in-flight update or redirect.
- Address fields, 4-byte instructions only:
  - index = pc[INDEX_WIDTH+1:2].
  - tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2].
  - Targets are stored as bits [ADDR_WIDTH-1:2]; [1:0] are reconstructed as 0.
- Lookup is combinational on o_pc_fetch, zero latency. btb_hit = valid[index] & (tag[index] == pc tag).
- Next PC, registered at posedge, priority high to low:
  1. i_redirect: i_redirect_pc with bits [1:0] forced to 0. Wins even when i_stall_fetch=1.
  2. i_stall_fetch: hold PC.
  3. btb_hit & i_bht_pred_taken: BTB target.
  4. Otherwise: PC+4.
- PC+4 wraps modulo 2^ADDR_WIDTH; no overflow flag.
- BTB write at posedge when i_btb_update & ~i_stall_fetch, same gating as the BHT update:
  - Entry at index(i_btb_update_pc) gets valid=1, tag, and target.
  - Overwrites any aliasing entry unconditionally; no replacement policy.
- Same-cycle write and lookup of the same index: the lookup sees the pre-write contents (no bypass). The new entry is visible the next cycle.
- Simultaneous i_redirect and i_btb_update: both take effect. The redirect sets the PC, the update writes the BTB, provided the stall gate is open.
- There is no BTB invalidate port. Entries persist until overwritten or reset.

Decomposition:
- Shared package `fetch_pkg`:
  - ADDR_WIDTH, INDEX_WIDTH, TAG_WIDTH (= ADDR_WIDTH-INDEX_WIDTH-2), BTB_SET_COUNT.
  - Packed struct btb_entry_t {valid, tag[TAG_WIDTH], target[ADDR_WIDTH-2]}.
  - Functions pc_index(pc) and pc_tag(pc).
- One sub-module, `btb_mem`:
  - Entry array with async-low valid clear.
  - Combinational read returning hit/target.
  - Gated synchronous write.
- fetch_pc_gen contains the PC register, the next-PC mux and the output logic.

Test Plan:
- Reset with i_arst_n=0, then release, no other inputs -> o_pc_fetch=0, then 4, 8, 12 on successive clocks; o_pred_taken=0 throughout.
- BTB update pc=0x40, target=0x200, stall=0; later fetch reaches 0x40 with i_bht_pred_taken=1 -> o_pred_taken=1, o_pred_target=0x200, next o_pc_fetch=0x200.
- Same BTB entry, fetch at 0x40 with i_bht_pred_taken=0 -> o_pred_taken=0, next PC=0x44. Fetch at an alias, 0x40+(1<<(INDEX_WIDTH+2))=0xC0 -> tag miss, next PC=0xC4, o_bht_set_index=0x10.
- i_stall_fetch=1 with i_redirect=1, i_redirect_pc=0x1003 -> next o_pc_fetch=0x1000. Stall=1 without redirect -> PC held for 3 cycles.
- i_btb_update=1 with i_stall_fetch=1 -> no write; a later lookup at that PC misses.
- Write index 5 while fetching the same index in the same cycle -> that cycle misses; the next fetch at that PC hits.
